wb_stage_seq: RTL and testbench

Registered, parametrised write-back stage for the 8-bit core. It accepts one retiring instruction per cycle over a valid/ready handshake and drives single-cycle write strobes to the register file, data memory and PC. It also splits double-width MUL/DIV results into two consecutive register writes, latches HALT as a sticky state, and counts retired instructions. It sits between the execute stage and the regFile / memoryBank / pc write ports.

---
 rtl/wb_stage_seq.sv | 134 +++++++++++++
 tb/tb_wb_stage_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_seq.sv
// Write-back stage: turns one retiring instruction per cycle into registered register-file,
// data-memory or PC write strobes, splitting MUL/DIV results into two register writes.
module wb_stage_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned MEM_AW = 4,
    parameter int unsigned PC_W   = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          opcode,
    input  logic                am,
    input  logic [REG_AW-1:0]   rd,
    input  logic [MEM_AW-1:0]   mem_addr,
    input  logic [PC_W-1:0]     instr_mem_addr,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                zero_flag,
    input  logic                carry_flag,
    input  logic                auxiliary_flag,
    input  logic                parity_flag,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                pc_load,
    output logic [PC_W-1:0]     pc_target,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [4:0] OpMove = 5'b00000, OpAdd  = 5'b00001, OpSub  = 5'b00010;
    localparam logic [4:0] OpMul  = 5'b00011, OpDiv  = 5'b00100, OpInc  = 5'b00101;
    localparam logic [4:0] OpDec  = 5'b00110, OpAnd  = 5'b00111, OpOr   = 5'b01000;
    localparam logic [4:0] OpNot  = 5'b01001, OpXor  = 5'b01010, OpLoad = 5'b01011;
    localparam logic [4:0] OpStore = 5'b01100, OpJump = 5'b01101, OpBeqz = 5'b01110;
    localparam logic [4:0] OpAshl = 5'b10000, OpAshr = 5'b10001, OpLshl = 5'b10010;
    localparam logic [4:0] OpLshr = 5'b10011, OpRotl = 5'b10100, OpRotr = 5'b10101;
    localparam logic [4:0] OpBc   = 5'b10110, OpBaux = 5'b10111, OpBpar = 5'b11000;
    localparam logic [4:0] OpCmp  = 5'b11001, OpHalt = 5'b11111;

    typedef enum logic [1:0] {StIdle, StWideHi, StHalt} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   hi_data_q;
    logic [REG_AW-1:0]   hi_addr_q;

    logic accept;
    logic am_dep, do_reg, do_mem, do_wide, do_pc, do_halt;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    // Unary ALU ops and shifts/rotates pick their destination from the addressing mode.
    always_comb begin
        am_dep  = opcode inside {OpInc, OpDec, OpNot, OpAshl, OpAshr, OpLshl, OpLshr,
                                 OpRotl, OpRotr};
        do_reg  = (opcode inside {OpMove, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpCmp, OpLoad})
                  || (am_dep && !am);
        do_mem  = (opcode == OpStore) || (am_dep && am);
        do_wide = (opcode == OpMul) || (opcode == OpDiv);
        do_pc   = (opcode == OpJump)
                  || ((opcode == OpBeqz) && zero_flag)
                  || ((opcode == OpBc)   && carry_flag)
                  || ((opcode == OpBaux) && auxiliary_flag)
                  || ((opcode == OpBpar) && parity_flag);
        do_halt = (opcode == OpHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hi_data_q <= '0;
            hi_addr_q <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            halted    <= 1'b0;
            retired   <= '0;
        end else begin
            rf_we   <= 1'b0;
            mem_we  <= 1'b0;
            pc_load <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        retired <= retired + CNT_W'(1);
                        if (do_reg || do_wide) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= alu_out[DATA_W-1:0];
                        end
                        if (do_mem) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= mem_addr;
                            mem_wdata <= alu_out[DATA_W-1:0];
                        end
                        if (do_pc) begin
                            pc_load   <= 1'b1;
                            pc_target <= instr_mem_addr;
                        end
                        if (do_wide) begin
                            hi_data_q <= alu_out[2*DATA_W-1:DATA_W];
                            hi_addr_q <= rd + REG_AW'(1);
                            state_q   <= StWideHi;
                        end
                        if (do_halt) begin
                            halted  <= 1'b1;
                            state_q <= StHalt;
                        end
                    end
                end
                StWideHi: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= hi_addr_q;
                    rf_wdata <= hi_data_q;
                    state_q  <= StIdle;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_seq.sv
// Randomized and directed bench for wb_stage_seq against an instruction-level reference model.
module tb_wb_stage_seq;

    localparam logic [4:0] MOVE = 5'b00000, ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00011;
    localparam logic [4:0] DIV = 5'b00100, INC = 5'b00101, DEC = 5'b00110, AND_ = 5'b00111;
    localparam logic [4:0] OR_ = 5'b01000, NOT_ = 5'b01001, XOR_ = 5'b01010, LOAD = 5'b01011;
    localparam logic [4:0] STORE = 5'b01100, JUMP = 5'b01101, BEQZ = 5'b01110;
    localparam logic [4:0] ASHL = 5'b10000, ASHR = 5'b10001, LSHL = 5'b10010, LSHR = 5'b10011;
    localparam logic [4:0] ROTL = 5'b10100, ROTR = 5'b10101, BC = 5'b10110, BAUX = 5'b10111;
    localparam logic [4:0] BPAR = 5'b11000, COMPARE = 5'b11001, HALT = 5'b11111;

    typedef struct packed {
        logic [4:0]  op;
        logic        am;
        logic [2:0]  rd;
        logic [3:0]  maddr;
        logic [5:0]  tgt;
        logic [15:0] alu;
        logic        z, c, a, p;
    } instr_t;

    typedef struct packed {
        logic       rf_we;
        logic [2:0] rf_waddr;
        logic [7:0] rf_wdata;
        logic       mem_we;
        logic [3:0] mem_waddr;
        logic [7:0] mem_wdata;
        logic       pc_load;
        logic [5:0] pc_target;
        logic       halted;
        logic [3:0] retired;
        logic       in_ready;
    } snap_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
    logic [4:0] opcode = '0;
    logic am = 1'b0;
    logic [2:0] rd = '0;
    logic [3:0] mem_addr = '0;
    logic [5:0] instr_mem_addr = '0;
    logic [15:0] alu_out = '0;
    logic zero_flag = 1'b0, carry_flag = 1'b0, auxiliary_flag = 1'b0, parity_flag = 1'b0;
    logic rf_we, mem_we, pc_load, halted;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata, mem_wdata;
    logic [3:0] mem_waddr, retired;
    logic [5:0] pc_target;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_retired = '0;
    logic       m_halted  = 1'b0;
    logic       m_hi_pend = 1'b0;
    logic [2:0] m_hi_addr = '0;
    logic [7:0] m_hi_data = '0;

    wb_stage_seq #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .am(am), .rd(rd), .mem_addr(mem_addr),
        .instr_mem_addr(instr_mem_addr), .alu_out(alu_out),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .auxiliary_flag(auxiliary_flag), .parity_flag(parity_flag),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .pc_load(pc_load), .pc_target(pc_target), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [4:0] op, input logic a_m, input logic [2:0] r,
                                  input logic [3:0] ma, input logic [5:0] t,
                                  input logic [15:0] alu, input logic [3:0] flags);
        instr_t i;
        i.op = op; i.am = a_m; i.rd = r; i.maddr = ma; i.tgt = t; i.alu = alu;
        {i.z, i.c, i.a, i.p} = flags;
        return i;
    endfunction

    function automatic instr_t rnd_instr(input logic [4:0] op);
        return mk(op, 1'($urandom), 3'($urandom), 4'($urandom), 6'($urandom),
                  16'($urandom), 4'($urandom));
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s = '{rf_we, rf_waddr, rf_wdata, mem_we, mem_waddr, mem_wdata, pc_load, pc_target,
              halted, retired, in_ready};
        return s;
    endfunction

    // Address/data fields only matter while their strobe is high.
    function automatic snap_t mask(input snap_t s);
        snap_t r = s;
        if (!r.rf_we)   begin r.rf_waddr = '0;  r.rf_wdata = '0;  end
        if (!r.mem_we)  begin r.mem_waddr = '0; r.mem_wdata = '0; end
        if (!r.pc_load) r.pc_target = '0;
        return r;
    endfunction

    // Expected outputs during the cycle following one clock edge.
    task automatic model_edge(input instr_t ins, input logic v, output snap_t e);
        logic shift_like;
        e = '0;
        shift_like = ins.op inside {INC, DEC, NOT_, ASHL, ASHR, LSHL, LSHR, ROTL, ROTR};
        if (m_hi_pend) begin
            e.rf_we = 1'b1; e.rf_waddr = m_hi_addr; e.rf_wdata = m_hi_data;
            m_hi_pend = 1'b0;
        end else if (!m_halted && v) begin
            m_retired = m_retired + 4'd1;
            if (ins.op == MUL || ins.op == DIV) begin
                e.rf_we = 1'b1; e.rf_waddr = ins.rd; e.rf_wdata = ins.alu[7:0];
                m_hi_pend = 1'b1;
                m_hi_addr = ins.rd + 3'd1;
                m_hi_data = ins.alu[15:8];
            end else if ((ins.op inside {MOVE, ADD, SUB, AND_, OR_, XOR_, COMPARE, LOAD})
                         || (shift_like && !ins.am)) begin
                e.rf_we = 1'b1; e.rf_waddr = ins.rd; e.rf_wdata = ins.alu[7:0];
            end else if (ins.op == STORE || (shift_like && ins.am)) begin
                e.mem_we = 1'b1; e.mem_waddr = ins.maddr; e.mem_wdata = ins.alu[7:0];
            end else if (ins.op == JUMP || (ins.op == BEQZ && ins.z) || (ins.op == BC && ins.c)
                         || (ins.op == BAUX && ins.a) || (ins.op == BPAR && ins.p)) begin
                e.pc_load = 1'b1; e.pc_target = ins.tgt;
            end else if (ins.op == HALT) begin
                m_halted = 1'b1;
            end
        end
        e.halted   = m_halted;
        e.retired  = m_retired;
        e.in_ready = !m_halted && !m_hi_pend;
    endtask

    task automatic drive(input instr_t ins, input logic v);
        @(negedge clk);
        in_valid = v; opcode = ins.op; am = ins.am; rd = ins.rd; mem_addr = ins.maddr;
        instr_mem_addr = ins.tgt; alu_out = ins.alu;
        {zero_flag, carry_flag, auxiliary_flag, parity_flag} = {ins.z, ins.c, ins.a, ins.p};
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and leaves it asserted; the model forgets everything.
    task automatic assert_reset();
        #2 rst_n = 1'b0;
        #1;
        m_retired = '0; m_halted = 1'b0; m_hi_pend = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        snap_t obs, exp;
        assert_reset();
        obs = sample(); exp = '0; exp.in_ready = 1'b1;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset: got %h required %h", obs, exp);
        end
        release_reset();
    endtask

    task automatic test_basic();
        instr_t seq[7];
        snap_t obs, exp;
        seq[0] = mk(ADD, 1'b0, 3'd2, 4'h0, 6'h00, 16'h0034, 4'b0000);
        seq[1] = mk(INC, 1'b1, 3'd5, 4'hA, 6'h00, 16'h0080, 4'b0000);
        seq[2] = mk(STORE, 1'b0, 3'd1, 4'h3, 6'h00, 16'h12C5, 4'b0000);
        seq[3] = mk(BEQZ, 1'b0, 3'd0, 4'h0, 6'h2A, 16'h0000, 4'b0111);
        seq[4] = mk(BEQZ, 1'b0, 3'd0, 4'h0, 6'h2A, 16'h0000, 4'b1000);
        seq[5] = mk(JUMP, 1'b0, 3'd0, 4'h0, 6'h15, 16'h0000, 4'b0000);
        seq[6] = mk(ROTL, 1'b0, 3'd6, 4'h0, 6'h00, 16'hFF5A, 4'b0000);
        foreach (seq[i]) begin
            for (int v = 0; v < 2; v++) begin
                model_edge(seq[i], v == 0, exp);
                drive(seq[i], v == 0);
                obs = sample();
                n_checks++;
                if (mask(obs) !== mask(exp)) begin
                    n_fail++;
                    $display("FAIL basic[%0d.%0d]: got %h required %h", i, v, obs, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        instr_t seq[8];
        snap_t obs, exp;
        seq[0] = mk(MUL, 1'b0, 3'd7, 4'h0, 6'h00, 16'hBEEF, 4'b0000);
        seq[1] = mk(MOVE, 1'b0, 3'd4, 4'h0, 6'h00, 16'h0011, 4'b0000);
        seq[2] = mk(MOVE, 1'b0, 3'd4, 4'h0, 6'h00, 16'h0011, 4'b0000);
        seq[3] = mk(DIV, 1'b1, 3'd3, 4'h0, 6'h00, 16'h7F01, 4'b0000);
        seq[4] = mk(SUB, 1'b0, 3'd1, 4'h0, 6'h00, 16'h0099, 4'b0000);
        seq[5] = mk(SUB, 1'b0, 3'd1, 4'h0, 6'h00, 16'h0099, 4'b0000);
        seq[6] = mk(BC, 1'b0, 3'd0, 4'h0, 6'h3F, 16'h0000, 4'b0100);
        seq[7] = mk(XOR_, 1'b0, 3'd0, 4'h0, 6'h00, 16'h00A5, 4'b0000);
        foreach (seq[i]) begin
            model_edge(seq[i], 1'b1, exp);
            drive(seq[i], 1'b1);
            obs = sample();
            n_checks++;
            if (mask(obs) !== mask(exp)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        instr_t ins;
        snap_t obs, exp;
        logic v;
        for (int i = 0; i < 400; i++) begin
            ins = rnd_instr(5'($urandom_range(0, 30)));
            v = ($urandom_range(0, 3) != 0);
            model_edge(ins, v, exp);
            drive(ins, v);
            obs = sample();
            n_checks++;
            if (mask(obs) !== mask(exp)) begin
                n_fail++;
                $display("FAIL random[%0d] op=%b: got %h required %h", i, ins.op, obs, exp);
            end
        end
    endtask

    task automatic test_halt();
        instr_t ins;
        snap_t obs, exp;
        model_edge(mk(HALT, 1'b0, 3'd0, 4'h0, 6'h0, 16'h0, 4'h0), 1'b1, exp);
        drive(mk(HALT, 1'b0, 3'd0, 4'h0, 6'h0, 16'h0, 4'h0), 1'b1);
        obs = sample();
        n_checks++;
        if (mask(obs) !== mask(exp)) begin
            n_fail++;
            $display("FAIL halt_accept: got %h required %h", obs, exp);
        end
        for (int i = 0; i < 6; i++) begin
            ins = rnd_instr(ADD);
            model_edge(ins, 1'b1, exp);
            drive(ins, 1'b1);
            obs = sample();
            n_checks++;
            if (mask(obs) !== mask(exp)) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %h required %h", i, obs, exp);
            end
        end
        assert_reset();
        n_checks++;
        if ({halted, in_ready, retired} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL halt_reset: got halted=%b in_ready=%b retired=%0d required 0 1 0",
                     halted, in_ready, retired);
        end
        release_reset();
    endtask

    task automatic test_reset_mid_wide();
        instr_t mul;
        snap_t obs, exp;
        mul = mk(MUL, 1'b0, 3'd5, 4'h0, 6'h00, 16'hC3D4, 4'b0000);
        model_edge(mul, 1'b1, exp);
        drive(mul, 1'b1);
        obs = sample();
        n_checks++;
        if (mask(obs) !== mask(exp)) begin
            n_fail++;
            $display("FAIL mid_wide_low: got %h required %h", obs, exp);
        end
        assert_reset();
        obs = sample(); exp = '0; exp.in_ready = 1'b1;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_wide_reset: got %h required %h", obs, exp);
        end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            model_edge(mul, 1'b0, exp);
            drive(mul, 1'b0);
            obs = sample();
            n_checks++;
            if (mask(obs) !== mask(exp)) begin
                n_fail++;
                $display("FAIL mid_wide_after[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_wrap();
        instr_t ins;
        snap_t exp;
        assert_reset();
        release_reset();
        for (int i = 0; i < 15; i++) begin
            ins = rnd_instr(MOVE);
            model_edge(ins, 1'b1, exp);
            drive(ins, 1'b1);
        end
        n_checks++;
        if (retired !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_15: got retired=%0d required 15", retired);
        end
        ins = rnd_instr(MOVE);
        model_edge(ins, 1'b1, exp);
        drive(ins, 1'b1);
        n_checks++;
        if (retired !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_0: got retired=%0d required 0", retired);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_reset_mid_wide();
        test_wrap();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
